// File: rtl/execute_sys_reg_commit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : execute_sys_reg_commit_pkg
// Purpose : Shared types and field indices for the system-register commit
//           stage: the commit FSM state encoding and PSR field positions.
// Rev     : 1.0  initial release
// ============================================================================
package execute_sys_reg_commit_pkg;

   // Commit FSM states.
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_IDT_WAIT = 2'd1,
      ST_BRANCH   = 2'd2
   } state_e;

   // PSR field positions.
   localparam int PSR_IM_BIT = 2;

endpackage
`default_nettype wire

// File: rtl/execute_sys_reg_commit.sv
`default_nettype none
// ============================================================================
// Module  : execute_sys_reg_commit
// Purpose : Commits results of the execute-stage system-register unit.
//           Holds the architectural PSR and IDTR and forwards ordinary
//           results to writeback with one cycle of latency. A PSR or IDTR
//           write stalls upstream, optionally hands the new IDTR to the
//           interrupt controller, then redirects fetch to the reload address.
// Ports   : iCLOCK/iRESET          clock, async active-high reset
//           iEXCEPTION_FLUSH       pipeline flush
//           iPREV_* / oPREV_BUSY   upstream result handshake
//           iDATA..iRELOAD_ADDR    result payload and control-write flags
//           iNEXT_BUSY / oNEXT_*   writeback handshake
//           oPSR/oIRQ_MASK/oIDTR   architectural state
//           oIDT_REQ / iIDT_ACK    IDTR update handshake to interrupt ctrl
//           oBRANCH_* / iBRANCH_ACK fetch-redirect handshake
// Rev     : 1.0  initial release
// ============================================================================
module execute_sys_reg_commit
   import execute_sys_reg_commit_pkg::*;
#(
   parameter logic [31:0] P_PSR_RESET  = 32'h0000_0000,
   parameter logic [31:0] P_IDTR_RESET = 32'h0000_0000,
   parameter int          P_IM_BIT     = PSR_IM_BIT
) (
   input  logic        iCLOCK,
   input  logic        iRESET,
   input  logic        iEXCEPTION_FLUSH,
   input  logic        iPREV_VALID,
   output logic        oPREV_BUSY,
   input  logic [31:0] iDATA,
   input  logic [4:0]  iDESTINATION,
   input  logic        iWB_EN,
   input  logic        iCTRL_PSR_VALID,
   input  logic        iCTRL_IDT_VALID,
   input  logic [31:0] iRELOAD_ADDR,
   input  logic        iNEXT_BUSY,
   output logic        oNEXT_VALID,
   output logic [31:0] oNEXT_DATA,
   output logic [4:0]  oNEXT_DESTINATION,
   output logic [31:0] oPSR,
   output logic        oIRQ_MASK,
   output logic [31:0] oIDTR,
   output logic        oIDT_REQ,
   input  logic        iIDT_ACK,
   output logic        oBRANCH_VALID,
   output logic [31:0] oBRANCH_ADDR,
   input  logic        iBRANCH_ACK
);

   state_e      r_state;
   state_e      w_state_next;
   logic        r_flush_pend;
   logic        w_busy;
   logic        w_accept;
   logic        w_is_idt;
   logic        w_is_psr;
   logic        w_is_ord;
   logic        r_next_valid;
   logic [31:0] r_next_data;
   logic [4:0]  r_next_dest;
   logic [31:0] r_psr;
   logic [31:0] r_idtr;
   logic [31:0] r_branch_addr;

   assign w_busy   = (r_state != ST_IDLE) | iNEXT_BUSY;
   assign w_accept = iPREV_VALID & ~w_busy & ~iEXCEPTION_FLUSH;

   // Accept is only possible in IDLE, so these decodes imply IDLE.
   // IDT wins if decode ever sets both flags.
   assign w_is_idt = w_accept & iCTRL_IDT_VALID;
   assign w_is_psr = w_accept & iCTRL_PSR_VALID & ~iCTRL_IDT_VALID;
   assign w_is_ord = w_accept & ~iCTRL_PSR_VALID & ~iCTRL_IDT_VALID;

   // ------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------
   always_ff @(posedge iCLOCK or posedge iRESET) begin
      if (iRESET) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------
   // FSM next-state
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_is_idt) begin
               w_state_next = ST_IDT_WAIT;
            end else if (w_is_psr) begin
               w_state_next = ST_BRANCH;
            end
         end
         ST_IDT_WAIT: begin
            // A flush seen at any point during the wait cancels the
            // redirect, but the IDTR handshake still has to finish.
            if (iIDT_ACK) begin
               if (iEXCEPTION_FLUSH | r_flush_pend) begin
                  w_state_next = ST_IDLE;
               end else begin
                  w_state_next = ST_BRANCH;
               end
            end
         end
         ST_BRANCH: begin
            if (iEXCEPTION_FLUSH | iBRANCH_ACK) begin
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Remembers a flush that arrived while waiting for the IDTR ack.
   always_ff @(posedge iCLOCK or posedge iRESET) begin
      if (iRESET) begin
         r_flush_pend <= 1'b0;
      end else begin
         r_flush_pend <= (r_state == ST_IDT_WAIT) & ~iIDT_ACK
                         & (r_flush_pend | iEXCEPTION_FLUSH);
      end
   end

   // ------------------------------------------------------------------
   // Architectural registers and redirect address
   // ------------------------------------------------------------------
   always_ff @(posedge iCLOCK or posedge iRESET) begin
      if (iRESET) begin
         r_psr         <= P_PSR_RESET;
         r_idtr        <= P_IDTR_RESET;
         r_branch_addr <= 32'h0000_0000;
      end else begin
         if (w_is_psr) begin
            r_psr <= iDATA;
         end
         if (w_is_idt) begin
            r_idtr <= iDATA;
         end
         if (w_is_psr | w_is_idt) begin
            r_branch_addr <= iRELOAD_ADDR;
         end
      end
   end

   // ------------------------------------------------------------------
   // Writeback output register
   // ------------------------------------------------------------------
   always_ff @(posedge iCLOCK or posedge iRESET) begin
      if (iRESET) begin
         r_next_valid <= 1'b0;
         r_next_data  <= 32'h0000_0000;
         r_next_dest  <= 5'd0;
      end else begin
         if (iEXCEPTION_FLUSH) begin
            r_next_valid <= 1'b0;
         end else if (w_is_ord) begin
            r_next_valid <= iWB_EN;
            r_next_data  <= iDATA;
            r_next_dest  <= iDESTINATION;
         end else if (!iNEXT_BUSY) begin
            // Result was consumed and nothing new arrived.
            r_next_valid <= 1'b0;
         end
      end
   end

`ifndef SYNTHESIS
   always @(posedge iCLOCK) begin
      if (!iRESET) begin
         assert (!(w_accept & iCTRL_PSR_VALID & iCTRL_IDT_VALID))
            else $error("execute_sys_reg_commit: PSR and IDTR write flags both set");
      end
   end
`endif

   assign oPREV_BUSY        = w_busy;
   assign oNEXT_VALID       = r_next_valid;
   assign oNEXT_DATA        = r_next_data;
   assign oNEXT_DESTINATION = r_next_dest;
   assign oPSR              = r_psr;
   assign oIRQ_MASK         = r_psr[P_IM_BIT];
   assign oIDTR             = r_idtr;
   assign oIDT_REQ          = (r_state == ST_IDT_WAIT);
   // Flush kills the redirect in the same cycle it is asserted.
   assign oBRANCH_VALID     = (r_state == ST_BRANCH) & ~iEXCEPTION_FLUSH;
   assign oBRANCH_ADDR      = r_branch_addr;

endmodule
`default_nettype wire

// File: tb/tb_execute_sys_reg_commit.sv
`default_nettype none
// ============================================================================
// Module  : tb_execute_sys_reg_commit
// Purpose : Directed self-checking bench for execute_sys_reg_commit.
//           Inputs change 2 time units after each rising edge; outputs are
//           sampled 1 time unit after that.
// Rev     : 1.0  initial release
// ============================================================================
module tb_execute_sys_reg_commit;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        prev_valid;
   logic        prev_busy;
   logic [31:0] data;
   logic [4:0]  dest;
   logic        wb_en;
   logic        psr_v;
   logic        idt_v;
   logic [31:0] reload;
   logic        next_busy;
   logic        next_valid;
   logic [31:0] next_data;
   logic [4:0]  next_dest;
   logic [31:0] psr;
   logic        irq_mask;
   logic [31:0] idtr;
   logic        idt_req;
   logic        idt_ack;
   logic        br_valid;
   logic [31:0] br_addr;
   logic        br_ack;

   int checks   = 0;
   int failures = 0;

   execute_sys_reg_commit #(
      .P_PSR_RESET  (32'h0000_0000),
      .P_IDTR_RESET (32'h0000_0000),
      .P_IM_BIT     (2)
   ) dut (
      .iCLOCK            (clk),
      .iRESET            (rst),
      .iEXCEPTION_FLUSH  (flush),
      .iPREV_VALID       (prev_valid),
      .oPREV_BUSY        (prev_busy),
      .iDATA             (data),
      .iDESTINATION      (dest),
      .iWB_EN            (wb_en),
      .iCTRL_PSR_VALID   (psr_v),
      .iCTRL_IDT_VALID   (idt_v),
      .iRELOAD_ADDR      (reload),
      .iNEXT_BUSY        (next_busy),
      .oNEXT_VALID       (next_valid),
      .oNEXT_DATA        (next_data),
      .oNEXT_DESTINATION (next_dest),
      .oPSR              (psr),
      .oIRQ_MASK         (irq_mask),
      .oIDTR             (idtr),
      .oIDT_REQ          (idt_req),
      .iIDT_ACK          (idt_ack),
      .oBRANCH_VALID     (br_valid),
      .oBRANCH_ADDR      (br_addr),
      .iBRANCH_ACK       (br_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
         else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
         end
   endtask

   // Advance to 2 units past the next rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      prev_valid = 1'b0;
      psr_v      = 1'b0;
      idt_v      = 1'b0;
      wb_en      = 1'b0;
      flush      = 1'b0;
      idt_ack    = 1'b0;
      br_ack     = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      data      = 32'h0;
      dest      = 5'd0;
      reload    = 32'h0;
      next_busy = 1'b0;
      idle_inputs();
      tick();
      tick();
      #1;
      chk("rst_psr",      psr,        32'h0);
      chk("rst_idtr",     idtr,       32'h0);
      chk("rst_nvalid",   next_valid, 32'h0);
      chk("rst_ndata",    next_data,  32'h0);
      chk("rst_bvalid",   br_valid,   32'h0);
      chk("rst_baddr",    br_addr,    32'h0);
      chk("rst_idtreq",   idt_req,    32'h0);
      chk("rst_busy",     prev_busy,  32'h0);
      rst = 1'b0;
      tick();

      // 1: ordinary result, latency 1
      prev_valid = 1'b1; data = 32'h1234_5678; dest = 5'd3; wb_en = 1'b1;
      tick();
      idle_inputs();
      #1;
      chk("ord_valid", next_valid, 32'h1);
      chk("ord_data",  next_data,  32'h1234_5678);
      chk("ord_dest",  next_dest,  32'd3);
      tick();
      #1;
      chk("ord_pulse", next_valid, 32'h0);

      // 5: writeback stall holds output, pending input waits
      prev_valid = 1'b1; data = 32'hA5A5_0001; dest = 5'd7; wb_en = 1'b1;
      tick();
      data = 32'h0000_DEAD; dest = 5'd9; next_busy = 1'b1;
      #1;
      chk("stall_busy1", prev_busy,  32'h1);
      chk("stall_v1",    next_valid, 32'h1);
      chk("stall_d1",    next_data,  32'hA5A5_0001);
      tick();
      #1;
      chk("stall_busy2", prev_busy,  32'h1);
      chk("stall_d2",    next_data,  32'hA5A5_0001);
      chk("stall_dst2",  next_dest,  32'd7);
      tick();
      next_busy = 1'b0;
      #1;
      chk("stall_rel",   prev_busy,  32'h0);
      chk("stall_d3",    next_data,  32'hA5A5_0001);
      tick();
      idle_inputs();
      #1;
      chk("stall_new_v", next_valid, 32'h1);
      chk("stall_new_d", next_data,  32'h0000_DEAD);
      chk("stall_new_t", next_dest,  32'd9);
      tick();

      // 2: PSR write, redirect
      prev_valid = 1'b1; psr_v = 1'b1; data = 32'h0000_0004; reload = 32'h0000_0100;
      tick();
      idle_inputs();
      #1;
      chk("psr_val",    psr,        32'h4);
      chk("psr_im",     irq_mask,   32'h1);
      chk("psr_bv",     br_valid,   32'h1);
      chk("psr_ba",     br_addr,    32'h100);
      chk("psr_busy",   prev_busy,  32'h1);
      chk("psr_nov",    next_valid, 32'h0);
      tick();
      #1;
      chk("psr_bv2",    br_valid,   32'h1);
      chk("psr_busy2",  prev_busy,  32'h1);
      br_ack = 1'b1;
      tick();
      br_ack = 1'b0;
      #1;
      chk("psr_bdone",  br_valid,   32'h0);
      chk("psr_free",   prev_busy,  32'h0);
      chk("psr_keep",   psr,        32'h4);

      // 3: IDTR write, ack after 3 cycles of request
      prev_valid = 1'b1; idt_v = 1'b1; data = 32'h0000_8000; reload = 32'h0000_0200;
      tick();
      idle_inputs();
      #1;
      chk("idt_req1",   idt_req,    32'h1);
      chk("idt_val",    idtr,       32'h8000);
      chk("idt_nobr",   br_valid,   32'h0);
      chk("idt_busy",   prev_busy,  32'h1);
      tick();
      #1;
      chk("idt_req2",   idt_req,    32'h1);
      tick();
      #1;
      chk("idt_req3",   idt_req,    32'h1);
      idt_ack = 1'b1;
      tick();
      idt_ack = 1'b0;
      #1;
      chk("idt_reqoff", idt_req,    32'h0);
      chk("idt_bv",     br_valid,   32'h1);
      chk("idt_ba",     br_addr,    32'h200);
      br_ack = 1'b1;
      tick();
      br_ack = 1'b0;
      #1;
      chk("idt_done",   prev_busy,  32'h0);

      // 4a: flush during IDT wait -> no redirect
      prev_valid = 1'b1; idt_v = 1'b1; data = 32'h0000_C000; reload = 32'h0000_0300;
      tick();
      idle_inputs();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      chk("fl_idt_req",  idt_req,   32'h1);
      chk("fl_idt_val",  idtr,      32'hC000);
      idt_ack = 1'b1;
      tick();
      idt_ack = 1'b0;
      #1;
      chk("fl_idt_rq0",  idt_req,   32'h0);
      chk("fl_idt_nobr", br_valid,  32'h0);
      chk("fl_idt_idle", prev_busy, 32'h0);
      chk("fl_idt_keep", idtr,      32'hC000);

      // 4b: flush during BRANCH drops valid in the same cycle
      prev_valid = 1'b1; psr_v = 1'b1; data = 32'h0000_0000; reload = 32'h0000_0400;
      tick();
      idle_inputs();
      #1;
      chk("fl_br_bv",   br_valid,  32'h1);
      chk("fl_br_im",   irq_mask,  32'h0);
      flush = 1'b1;
      #1;
      chk("fl_br_now",  br_valid,  32'h0);
      tick();
      flush = 1'b0;
      #1;
      chk("fl_br_bv2",  br_valid,  32'h0);
      chk("fl_br_idle", prev_busy, 32'h0);

      // flush in IDLE drops the incoming result
      prev_valid = 1'b1; data = 32'h0000_0011; dest = 5'd4; wb_en = 1'b1; flush = 1'b1;
      tick();
      idle_inputs();
      #1;
      chk("fl_idle_nv", next_valid, 32'h0);

      // ack without request is ignored
      idt_ack = 1'b1;
      tick();
      idt_ack = 1'b0;
      #1;
      chk("stray_ack_busy", prev_busy, 32'h0);
      chk("stray_ack_br",   br_valid,  32'h0);

      // 6: reset during BRANCH
      prev_valid = 1'b1; psr_v = 1'b1; data = 32'hFFFF_FFFF; reload = 32'h0000_0500;
      tick();
      idle_inputs();
      #1;
      chk("rb_bv",     br_valid,  32'h1);
      chk("rb_psr",    psr,       32'hFFFF_FFFF);
      rst = 1'b1;
      #1;
      chk("rb_bv0",    br_valid,  32'h0);
      chk("rb_psr0",   psr,       32'h0);
      chk("rb_baddr0", br_addr,   32'h0);
      tick();
      rst = 1'b0;
      prev_valid = 1'b1; data = 32'h0000_CAFE; dest = 5'd1; wb_en = 1'b1;
      #1;
      chk("rb_busy",   prev_busy, 32'h0);
      tick();
      idle_inputs();
      #1;
      chk("rb_nv",     next_valid, 32'h1);
      chk("rb_nd",     next_data,  32'h0000_CAFE);
      chk("rb_nt",     next_dest,  32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
